// File: rtl/boot_loader_if.sv
// Byte-stream ingress plus RAM write port and boot status for the program loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready is driven by the loader; the RAM side never stalls.
interface boot_loader_if #(
  parameter int WIDTH = 16
) ();
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             mem_we;
  logic             cpu_hold;
  logic             done;
  logic             error;

  // Upstream byte source and RAM/CPU observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Power-up program loader: parses SYNC/ADDR/LEN/DATA/CSUM frames and writes words into RAM.
// Latency: mem_we asserts the cycle after the edge that accepts a word's last byte.
// Backpressure: in_ready is low only after a good load (DONE); otherwise every byte is accepted.
module boot_loader #(
  parameter int         WIDTH   = 16,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input logic       clk,
  input logic       reset,
  boot_loader_if.slave bus
);

  localparam int              BPW       = WIDTH / 8;
  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [0:0]      LAST_BYTE = 1'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [0:0]       r_bcnt;      // byte position inside the current multi-byte field
  logic [WIDTH-1:0] r_word;      // partially assembled field
  logic [WIDTH-1:0] r_addr;      // next RAM write address
  logic [WIDTH-1:0] r_cnt;       // words still to be received
  logic [7:0]       r_sum;       // running data-byte checksum
  logic [TW-1:0]    r_idle;      // idle cycles since last accepted byte
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_data;

  logic             w_rdy;
  logic             w_acc;
  logic             w_is_sync;
  logic             w_last_byte;
  logic             w_active;
  logic             w_timeout;
  logic [WIDTH-1:0] w_asm;

  // Ready depends on state only, so it never combinationally follows in_valid.
  assign w_rdy       = (r_state != S_DONE);
  assign w_acc       = bus.in_valid & w_rdy;
  assign w_is_sync   = (bus.in_data == SYNC);
  assign w_last_byte = (r_bcnt == LAST_BYTE);
  assign w_active    = (r_state == S_ADDR) || (r_state == S_LEN) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout   = (TIMEOUT != 0) && w_active && !w_acc && (r_idle == IDLE_LAST);

  assign bus.in_ready = w_rdy;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.cpu_hold = (r_state != S_DONE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.error    = (r_state == S_ERR);

  // Drop the incoming byte into its little-endian slot of the field being assembled.
  always_comb begin
    w_asm = r_word;
    for (int b = 0; b < BPW; b++) begin
      if (int'(r_bcnt) == b) begin
        w_asm[8*b +: 8] = bus.in_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame parser next-state; a timeout overrides any hold in an in-frame state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_is_sync) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_acc && w_last_byte) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_acc && w_last_byte) w_next = (w_asm == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: begin
        if (w_acc && w_last_byte && (r_cnt == WIDTH'(1))) w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_acc) w_next = (bus.in_data == r_sum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      S_ERR: begin
        if (w_acc && w_is_sync) w_next = S_ADDR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  // Idle counter: runs only inside a frame and restarts on every accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle <= '0;
    end else if (!w_active || w_acc) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TW'(1);
    end
  end

  // Field assembly, checksum, address/count tracking and the one-cycle write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcnt     <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_IDLE, S_ERR: begin
            if (w_is_sync) begin
              r_sum  <= '0;
              r_bcnt <= '0;
            end
          end
          S_ADDR: begin
            r_word <= w_asm;
            r_bcnt <= w_last_byte ? 1'b0 : r_bcnt + 1'b1;
            if (w_last_byte) r_addr <= w_asm;
          end
          S_LEN: begin
            r_word <= w_asm;
            r_bcnt <= w_last_byte ? 1'b0 : r_bcnt + 1'b1;
            if (w_last_byte) r_cnt <= w_asm;
          end
          S_DATA: begin
            r_word <= w_asm;
            r_sum  <= r_sum + bus.in_data;
            r_bcnt <= w_last_byte ? 1'b0 : r_bcnt + 1'b1;
            if (w_last_byte) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_addr;
              r_mem_data <= w_asm;
              r_addr     <= r_addr + WIDTH'(1);
              r_cnt      <= r_cnt - WIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
